// File: rtl/apb_regfile_slave.sv
// APB register-file slave: DEPTH words with byte strobes, optional wait states,
// read-only low words, and PSLVERR on range, alignment or read-only violations.
module apb_regfile_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RO_WORDS    = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDXC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              misaligned;
    logic              ro_hit;
    logic              err_c;
    logic              ready_c;
    logic              setup_c;
    logic [DATA_W-1:0] rd_word;

    // Decode of the captured request; live bus values are never used in ACCESS.
    assign word_idx     = req_q.addr >> OFF_W;
    assign out_of_range = {1'b0, word_idx} >= IDXC_W'(DEPTH);
    assign misaligned   = (req_q.addr & OFF_MASK) != '0;

    if (RO_WORDS == 0) begin : g_no_ro
        assign ro_hit = 1'b0;
    end else begin : g_ro
        assign ro_hit = {1'b0, word_idx} < IDXC_W'(RO_WORDS);
    end

    assign err_c   = out_of_range | misaligned | (req_q.write & ro_hit);
    assign setup_c = PSELx & ~PENABLE;
    assign ready_c = ~PRESET & (state_q == ACCESS) & PSELx & PENABLE & (cnt_q == '0);

    // Read mux over the storage array, only meaningful when the index is in range.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (word_idx == ADDR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    assign PREADY  = ready_c;
    assign PSLVERR = ready_c & err_c;
    assign PRDATA  = (ready_c && !req_q.write && !err_c) ? rd_word : '0;

    // Next-state, request capture, wait counting and strobed memory update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            IDLE, DONE: begin
                if (setup_c) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    req_d   = '{write: PWRITE, addr: PADDR, wdata: PWDATA, strb: PSTRB};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_d = IDLE;
                end else if (ready_c) begin
                    state_d = DONE;
                    if (req_q.write && !err_c) begin
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            if (word_idx == ADDR_W'(i)) begin
                                for (int b = 0; b < int'(STRB_W); b++) begin
                                    if (req_q.strb[b]) begin
                                        mem_d[i][8*b +: 8] = req_q.wdata[8*b +: 8];
                                    end
                                end
                            end
                        end
                    end
                end else if (PENABLE && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronous reset clears the FSM, counter, holding registers and all storage.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning PWDATA/PRDATA width; legal values are 8, 16, 32, 64.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning byte-address width of PADDR.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning number of DATA_W-bit storage words; legal range is 1..2^(ADDR_W-log2(DATA_W/8)).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, meaning PREADY-low access cycles inserted before completion; legal range is 0..15.
REQ-005 The block SHALL have parameter RO_WORDS, default 0, meaning that word indices 0..RO_WORDS-1 are read-only.
REQ-006 The block SHALL have port PCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port PSELx, input, 1 bit: slave select.
REQ-009 The block SHALL have port PENABLE, input, 1 bit: access phase.
REQ-010 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have port PADDR, input, ADDR_W bits: byte address.
REQ-012 The block SHALL have port PWDATA, input, DATA_W bits: write data.
REQ-013 The block SHALL have port PSTRB, input, DATA_W/8 bits: write byte enables; ignored on reads.
REQ-014 The block SHALL have port PREADY, output, 1 bit: transfer completion.
REQ-015 The block SHALL have port PRDATA, output, DATA_W bits: read data.
REQ-016 The block SHALL have port PSLVERR, output, 1 bit: transfer error, valid only while PREADY=1.

Function
REQ-017 The block SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-018 The FSM SHALL transition as follows:
- IDLE->ACCESS on PSELx=1, PENABLE=0.
- ACCESS->DONE when the PREADY=1 cycle completes.
- DONE->ACCESS on PSELx=1, PENABLE=0 (back-to-back transfer).
- DONE->IDLE otherwise.
REQ-019 On the IDLE/DONE->ACCESS edge, the block SHALL capture PADDR, PWRITE, PWDATA and PSTRB into holding registers, and SHALL load the wait counter with WAIT_CYCLES.
REQ-020 In ACCESS, the wait counter SHALL decrement by 1 each cycle in which PSELx=1, PENABLE=1 and the count is non-zero.
REQ-021 PREADY SHALL equal 1 iff state=ACCESS, PSELx=1, PENABLE=1 and count=0.
- Latency: WAIT_CYCLES=0 gives a two-cycle zero-wait transfer.
- Otherwise the transfer takes WAIT_CYCLES+2 cycles.
REQ-022 The word index SHALL be captured PADDR >> log2(DATA_W/8).
REQ-023 An error condition SHALL be any of:
- the word index is >= DEPTH;
- PADDR low log2(DATA_W/8) bits are non-zero (misaligned);
- a write targets a word index < RO_WORDS.
REQ-024 On an error-free write, at the PREADY=1 edge, the block SHALL update each byte lane i of mem[index] with PWDATA lane i iff PSTRB[i]=1; PSTRB=0 is a legal no-op write.
REQ-025 On an error-free read, while PREADY=1, PRDATA SHALL equal mem[index].
REQ-026 PRDATA SHALL be 0 at all other times, including during errored reads.
REQ-027 On an errored transfer, PSLVERR SHALL be 1 during the PREADY=1 cycle, and memory SHALL remain unchanged.
REQ-028 PSLVERR SHALL be 0 whenever PREADY=0.
REQ-029 If PSELx falls while in ACCESS before completion, the block SHALL return to IDLE next cycle, with no write and no response.
REQ-030 If PSELx=1, PENABLE=1 is seen in IDLE (no setup phase), the block SHALL ignore it, keep PREADY=0 and stay in IDLE.
REQ-031 Changes to PADDR, PWRITE, PWDATA or PSTRB during ACCESS SHALL be ignored; the captured values are used.

Reset
REQ-032 While PRESET=1 at a rising PCLK, the block SHALL go to state IDLE, set the wait counter to 0, and clear all DEPTH words to 0.
REQ-033 During reset, PREADY, PRDATA and PSLVERR SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no memory write; the first cycle after PRESET falls is IDLE.

Verification (DATA_W=32, ADDR_W=12, DEPTH=32, WAIT_CYCLES=2, RO_WORDS=1)
REQ-035 Write then read: write 0xDEADBEEF to 0x008 with PSTRB=0xF, then read 0x008 -> PREADY low 2 access cycles then high 1 cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-036 Byte strobes: after REQ-035, write 0x11223344 to 0x008 with PSTRB=0x5, then read -> PRDATA=0xDE22BE44.
REQ-037 Errors:
- Write to 0x000 (read-only) -> PSLVERR=1; a later read of 0x000 returns 0.
- Read of 0x080 (index 32) -> PSLVERR=1, PRDATA=0.
- Read of 0x00A (misaligned) -> PSLVERR=1.
REQ-038 Abort: drop PSELx after 1 access cycle of a write of 0xA5A5A5A5 to 0x00C -> no PREADY; a later read of 0x00C returns 0.
REQ-039 Reset mid-transfer: PRESET=1 during ACCESS of a write to 0x010 -> outputs 0; after release, a read of 0x010 returns 0 and previously written words read 0.
REQ-040 Back-to-back: setup immediately after a DONE cycle, with WAIT_CYCLES=0 build -> each transfer completes in exactly 2 cycles, and consecutive PREADY pulses are 2 cycles apart.
